pwm_mode_select: RTL

- Parametrised successor to the fixed four-switch PWM output selector.
- Routes one of NUM_MODES PWM generator groups (each NUM_CH lanes wide) to the board outputs, e.g. RGB LED lanes or a servo lane.
- Adds switch synchronisation, debounce and one-hot validation.
- Mode changes take effect only at a PWM period boundary, with a timeout fallback, so no runt pulses reach the LEDs or servo.

---
 rtl/pwm_mode_select.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_mode_select.sv
// rtl/pwm_mode_select.sv - debounced, period-aligned PWM group selector (optional SWITCH_BLANK_EN)
module pwm_mode_select #(
    parameter int NUM_MODES       = 4,
    parameter int NUM_CH          = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MODES-1:0]        sw,
    input  logic [NUM_MODES*NUM_CH-1:0] mode_pwm,
    input  logic                        period_tick,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic [NUM_MODES-1:0]        active_mode,
    output logic                        pending,
    output logic                        sel_error
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam int TW = (TICK_TIMEOUT > 0) ? $clog2(TICK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TICK_TIMEOUT > 0) ? TICK_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TICK_TIMEOUT > 0);
    localparam logic [NUM_MODES-1:0] ONE = NUM_MODES'(1);

`ifdef SWITCH_BLANK_EN
    typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;
`else
    typedef enum logic [0:0] {RUN, PEND} state_t;
`endif

    logic [NUM_MODES-1:0] sw_m, sw_s, sw_prev, req;
    logic [DW-1:0]        deb_cnt;
    logic                 stable, sw_onehot;
    state_t               state, state_nx;
    logic [NUM_MODES-1:0] active_nx;
    logic [TW-1:0]        tcnt, tcnt_nx;
    logic                 timeout_hit;
    logic [NUM_CH-1:0]    sel_lanes;

    assign stable      = (sw_s == sw_prev);
    assign sw_onehot   = (sw_s != '0) && ((sw_s & (sw_s - ONE)) == '0);
    assign timeout_hit = TO_EN && (tcnt == TO_LAST);
    assign pending     = (state != RUN);

    // Synchronise the switches, count stable cycles, accept a validated request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_m      <= '0;
            sw_s      <= '0;
            sw_prev   <= '0;
            deb_cnt   <= '0;
            req       <= '0;
            sel_error <= 1'b0;
        end else begin
            sw_m    <= sw;
            sw_s    <= sw_m;
            sw_prev <= sw_s;
            if (!stable)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + 1'b1;
            // Only accept when the value is still unchanged this cycle
            if (stable && (deb_cnt == DEB_MAX)) begin
                req       <= sw_onehot ? sw_s : '0;
                sel_error <= !sw_onehot;
            end
        end
    end

    // Mode FSM state, active group and timeout counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            active_mode <= '0;
            tcnt        <= '0;
        end else begin
            state       <= state_nx;
            active_mode <= active_nx;
            tcnt        <= tcnt_nx;
        end
    end

    // Next-state: wait in PEND for a period boundary (or timeout) before switching
    always_comb begin
        state_nx  = state;
        active_nx = active_mode;
        tcnt_nx   = tcnt;
        case (state)
            RUN: begin
                if (req != active_mode) begin
                    state_nx = PEND;
                    tcnt_nx  = '0;
                end
            end
            PEND: begin
                if (req == active_mode) begin
                    state_nx = RUN;
                end else if (period_tick || timeout_hit) begin
                    active_nx = req;
`ifdef SWITCH_BLANK_EN
                    state_nx  = BLANK;
`else
                    state_nx  = RUN;
`endif
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
`ifdef SWITCH_BLANK_EN
            BLANK: begin
                if (period_tick)
                    state_nx = RUN;
            end
`endif
            default: state_nx = RUN;
        endcase
    end

    // Pick the lanes of the active group; nothing when no group is active
    always_comb begin
        sel_lanes = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (active_mode[m])
                sel_lanes = sel_lanes | mode_pwm[m*NUM_CH +: NUM_CH];
        end
    end

    // Registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out <= '0;
        end else begin
`ifdef SWITCH_BLANK_EN
            pwm_out <= (state == BLANK) ? '0 : sel_lanes;
`else
            pwm_out <= sel_lanes;
`endif
        end
    end

endmodule
